pri_arbiter: RTL and testbench

PRI_ARBITER -- requirements
Module: pri_arbiter

---
 rtl/pri_arb_pkg.sv | 6 +
 rtl/pri_arbiter_pri_enc.sv | 29 ++
 rtl/pri_arbiter.sv | 52 +++++
 tb/tb_pri_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pri_arb_pkg.sv
// pri_arb_pkg: shared mode and state encodings for the priority arbiter.
package pri_arb_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/pri_arbiter_pri_enc.sv
// pri_enc: rotated highest-index search, scanning start, start-1, ..., 0, N-1, ..., start+1.
module pri_enc #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);
    int t;
    logic [W-1:0] p;
    // Walk from the lowest priority up so the last hit is the winner.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        t     = 0;
        p     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            t = int'(start) - k;
            if (t < 0) t = t + N;
            p = W'(t);
            if (vec[p]) begin
                found = 1'b1;
                idx   = p;
            end
        end
    end
endmodule

// File: rtl/pri_arbiter.sv
// pri_arbiter: fixed-priority / round-robin arbiter with registered grant held until ack.
module pri_arbiter
    import pri_arb_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);
    state_t       state;
    logic [W-1:0] last;
    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic         found;
    logic [W-1:0] win;
    logic         accept;

    assign accept = (state == GRANT) && ack;
    // The pointer an accepted grant is about to write is already used for this arbitration.
    assign ptr    = accept ? gnt_idx : last;
    assign start  = (mode == MODE_RR && ptr != '0) ? ptr - 1'b1 : W'(N - 1);

    pri_enc #(.N(N)) u_enc (
        .vec   (req),
        .start (start),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= '0;
            gnt_vld    <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else if (state == IDLE || ack) begin
            if (accept) last <= gnt_idx;
            state      <= found ? GRANT : IDLE;
            gnt_vld    <= found;
            gnt_idx    <= found ? win : '0;
            gnt_onehot <= found ? {{(N-1){1'b0}}, 1'b1} << win : '0;
        end
    end
endmodule

// File: tb/tb_pri_arbiter.sv
// tb_pri_arbiter: table-driven check of an N=8 arbiter plus a hand-written N=5 round-robin sequence.
module tb_pri_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       mode = 1'b0;
    logic       ack = 1'b0;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;

    logic       rst5_n = 1'b0;
    logic [4:0] req5 = '0;
    logic       mode5 = 1'b0;
    logic       ack5 = 1'b0;
    logic       gnt_vld5;
    logic [2:0] gnt_idx5;
    logic [4:0] gnt_onehot5;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pri_arbiter #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .ack(ack),
        .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot)
    );

    pri_arbiter #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst5_n), .req(req5), .mode(mode5), .ack(ack5),
        .gnt_vld(gnt_vld5), .gnt_idx(gnt_idx5), .gnt_onehot(gnt_onehot5)
    );

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       mode;
        logic       ack;
        logic       vld;
        logic [2:0] idx;
        logic [7:0] oh;
    } vec_t;

    vec_t tv[32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Each row: inputs applied for one edge, then the registered outputs expected after it.
        tv[0]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        tv[1]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        tv[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80};
        tv[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        tv[4]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20};
        tv[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20};
        tv[6]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20};
        tv[7]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01};
        tv[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        tv[9]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        for (int k = 0; k < 7; k++)
            tv[10 + k] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 3'(6 - k), 8'h40 >> k};
        tv[17] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        tv[18] = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01};
        tv[19] = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        tv[20] = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01};
        tv[21] = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        tv[22] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
        tv[23] = '{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08};
        tv[24] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
        tv[25] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80};
        tv[26] = '{1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08};
        tv[27] = '{1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02};
        tv[28] = '{1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08};
        tv[29] = '{1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40};
        tv[30] = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 3'd6, 8'h40};
        tv[31] = '{1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rst_n = tv[i].rst_n;
            req   = tv[i].req;
            mode  = tv[i].mode;
            ack   = tv[i].ack;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_vld", i), 64'(gnt_vld), 64'(tv[i].vld));
            check($sformatf("v%0d_idx", i), 64'(gnt_idx), 64'(tv[i].idx));
            check($sformatf("v%0d_onehot", i), 64'(gnt_onehot), 64'(tv[i].oh));
        end

        // N=5: round-robin wrap must stay modulo 5.
        @(negedge clk);
        rst5_n = 1'b0;
        req5   = 5'b11111;
        mode5  = 1'b1;
        ack5   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("n5_rst_vld", 64'(gnt_vld5), 64'd0);
        check("n5_rst_idx", 64'(gnt_idx5), 64'd0);
        check("n5_rst_onehot", 64'(gnt_onehot5), 64'd0);
        @(negedge clk);
        rst5_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("n5_s%0d_vld", i), 64'(gnt_vld5), 64'd1);
            check($sformatf("n5_s%0d_idx", i), 64'(gnt_idx5), 64'(i == 5 ? 4 : 4 - i));
            check($sformatf("n5_s%0d_onehot", i), 64'(gnt_onehot5), 64'(5'b10000 >> (i == 5 ? 0 : i)));
            check($sformatf("n5_s%0d_range", i), 64'(gnt_idx5 <= 3'd4), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
